// File: rtl/simon_dice_param.sv
// Parametrised Simon memory game.
// An LFSR draws one new step per round; the sequence is replayed on the LEDs, then the player
// must repeat it on the buttons within a per-press timeout. All pacing uses cycle counters in
// the single clock domain. Outputs are registered and follow the state entered at each edge.
module simon_dice_param #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned SHOW_TICKS    = 25000000,
    parameter int unsigned GAP_TICKS     = 12500000,
    parameter int unsigned TIMEOUT_TICKS = 250000000,
    localparam int unsigned IDXW         = (N_BTN > 1) ? $clog2(N_BTN) : 1,
    localparam int unsigned SW           = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] led,
    output logic [SW-1:0]    score,
    output logic             busy,
    output logic             win,
    output logic             lose
);

    // Index width for sequence positions 0..MAX_LEN-1.
    localparam int unsigned LW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // One shared timer covers show, gap and timeout phases; size it for the longest.
    localparam int unsigned TMAX_SG = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned TMAX    = (TMAX_SG > TIMEOUT_TICKS) ? TMAX_SG : TIMEOUT_TICKS;
    localparam int unsigned TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StShowOn,
        StShowOff,
        StWait,
        StWin,
        StLose
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [SW-1:0]     len_q, len_d;
    logic [SW-1:0]     score_q, score_d;
    logic [LW-1:0]     show_idx_q, show_idx_d;
    logic [LW-1:0]     in_idx_q, in_idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_BTN-1:0]  btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0]  led_q, led_d;
    logic              busy_q, busy_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;

    logic [IDXW-1:0]   mem_q [MAX_LEN];

    logic [N_BTN-1:0]  rise;
    logic [LW-1:0]     last_idx;
    logic [LW-1:0]     wr_idx;
    logic              mem_we;
    logic              lfsr_fb;
    logic [15:0]       lfsr_next;
    logic [N_BTN-1:0]  exp_onehot;
    logic [IDXW-1:0]   show_val;

    function automatic logic [N_BTN-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [N_BTN-1:0] v;
        v = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (idx == IDXW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Press detection, sequence bookkeeping and LFSR step.
    always_comb begin
        rise       = button & ~btn_prev_q;
        last_idx   = LW'(len_q - SW'(1));
        wr_idx     = LW'(len_q);
        mem_we     = (state_q == StAdd);
        lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_next  = {lfsr_q[14:0], lfsr_fb};
        exp_onehot = onehot(mem_q[in_idx_q]);
    end

    // Next-state logic of the game FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        len_d      = len_q;
        score_d    = score_q;
        show_idx_d = show_idx_q;
        in_idx_d   = in_idx_q;
        timer_d    = timer_q;
        btn_prev_d = button;

        case (state_q)
            StIdle, StWin, StLose: begin
                if (start) begin
                    state_d = StAdd;
                    lfsr_d  = (seed == 16'h0000) ? 16'h0001 : seed;
                    len_d   = '0;
                    score_d = '0;
                end
            end
            StAdd: begin
                len_d      = len_q + SW'(1);
                lfsr_d     = lfsr_next;
                show_idx_d = '0;
                timer_d    = '0;
                state_d    = StShowOn;
            end
            StShowOn: begin
                if (timer_q == SHOW_LAST) begin
                    timer_d = '0;
                    state_d = StShowOff;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StShowOff: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (show_idx_q == last_idx) begin
                        in_idx_d = '0;
                        state_d  = StWait;
                    end else begin
                        show_idx_d = show_idx_q + LW'(1);
                        state_d    = StShowOn;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWait: begin
                // A press in the final timeout cycle still counts.
                if (rise != '0) begin
                    timer_d = '0;
                    if (rise == exp_onehot) begin
                        if (in_idx_q == last_idx) begin
                            score_d = len_q;
                            state_d = (len_q == SW'(MAX_LEN)) ? StWin : StAdd;
                        end else begin
                            in_idx_d = in_idx_q + LW'(1);
                        end
                    end else begin
                        state_d = StLose;
                    end
                end else if (timer_q == TOUT_LAST) begin
                    state_d = StLose;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the state being entered so the registered outputs line up with it.
    always_comb begin
        // The entry written in ADD is not in the memory yet; forward it for round 1.
        show_val = (mem_we && (wr_idx == show_idx_d)) ? lfsr_q[IDXW-1:0] : mem_q[show_idx_d];
        led_d    = '0;
        busy_d   = 1'b0;
        win_d    = 1'b0;
        lose_d   = 1'b0;
        case (state_d)
            StAdd:     busy_d = 1'b1;
            StShowOn: begin
                busy_d = 1'b1;
                led_d  = onehot(show_val);
            end
            StShowOff: busy_d = 1'b1;
            StWait: begin
                busy_d = 1'b1;
                led_d  = button;
            end
            StWin: begin
                win_d = 1'b1;
                led_d = '1;
            end
            StLose:    lose_d = 1'b1;
            default:   ;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lfsr_q     <= 16'h0001;
            len_q      <= '0;
            score_q    <= '0;
            show_idx_q <= '0;
            in_idx_q   <= '0;
            timer_q    <= '0;
            btn_prev_q <= '0;
            led_q      <= '0;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            len_q      <= len_d;
            score_q    <= score_d;
            show_idx_q <= show_idx_d;
            in_idx_q   <= in_idx_d;
            timer_q    <= timer_d;
            btn_prev_q <= btn_prev_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    // Sequence store: plain registers, contents are only read after being written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx] <= lfsr_q[IDXW-1:0];
        end
    end

    assign led   = led_q;
    assign score = score_q;
    assign busy  = busy_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: tb/tb_simon_dice_param.sv
// Directed bench for simon_dice_param with N_BTN=4, MAX_LEN=3, SHOW=4, GAP=2, TIMEOUT=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_simon_dice_param;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] seed;
    logic [3:0]  button;
    logic [3:0]  led;
    logic [1:0]  score;
    logic        busy;
    logic        win;
    logic        lose;

    int vectors;
    int miscompares;

    // Sequence produced by seed 1 (and by seed 0, which is replaced by 1).
    int seq [3] = '{1, 2, 0};

    simon_dice_param #(
        .N_BTN        (4),
        .MAX_LEN      (3),
        .SHOW_TICKS   (4),
        .GAP_TICKS    (2),
        .TIMEOUT_TICKS(20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .seed  (seed),
        .button(button),
        .led   (led),
        .score (score),
        .busy  (busy),
        .win   (win),
        .lose  (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the ADD cycle; checks the whole replay of R steps and returns in the first
    // WAIT cycle.
    task automatic expect_round(input int r);
        logic [3:0] one;
        check("add_busy", busy, 1);
        check("add_led", led, 4'b0000);
        for (int s = 0; s < r; s++) begin
            one = 4'b0001 << seq[s];
            for (int c = 0; c < 4; c++) begin
                tick(1);
                check("show_on_led", led, one);
            end
            for (int c = 0; c < 2; c++) begin
                tick(1);
                check("show_off_led", led, 4'b0000);
            end
        end
        tick(1);
        check("wait_busy", busy, 1);
        check("wait_lose", lose, 0);
    endtask

    // One press-and-release. A non-final press gets an idle cycle so the next rise is clean.
    task automatic press_step(input int idx, input bit last);
        button = 4'b0001 << idx;
        tick(1);
        button = 4'b0000;
        if (!last) tick(1);
    endtask

    task automatic start_game(input logic [15:0] s);
        seed  = s;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        seed        = 16'h0000;
        button      = 4'b0000;
        tick(2);
        check("rst_led", led, 4'b0000);
        check("rst_score", score, 0);
        check("rst_busy", busy, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", busy, 0);

        // Full game to WIN.
        start_game(16'h0001);
        expect_round(1);
        press_step(1, 1);
        check("r1_score", score, 1);
        expect_round(2);
        press_step(1, 0);
        press_step(2, 1);
        check("r2_score", score, 2);
        expect_round(3);
        press_step(1, 0);
        press_step(2, 0);
        press_step(0, 1);
        check("win_led", led, 4'b1111);
        check("win_flag", win, 1);
        check("win_score", score, 3);
        check("win_busy", busy, 0);
        check("win_lose", lose, 0);

        // Restart from WIN, then a wrong press.
        start_game(16'h0001);
        check("restart_win_clr", win, 0);
        expect_round(1);
        press_step(3, 1);
        check("wrong_lose", lose, 1);
        check("wrong_led", led, 4'b0000);
        check("wrong_score", score, 0);
        check("wrong_busy", busy, 0);

        // Restart from LOSE, then timeout in round 2.
        start_game(16'h0001);
        check("restart_lose_clr", lose, 0);
        expect_round(1);
        press_step(1, 1);
        expect_round(2);
        tick(19);
        check("tout_last_cycle", lose, 0);
        tick(1);
        check("tout_lose", lose, 1);
        check("tout_score", score, 1);

        // Press in the final timeout cycle is accepted.
        start_game(16'h0001);
        expect_round(1);
        press_step(1, 1);
        expect_round(2);
        tick(19);
        press_step(1, 0);
        check("late_press_lose", lose, 0);
        check("late_press_busy", busy, 1);
        press_step(2, 1);
        check("late_press_score", score, 2);

        // start while busy is ignored, then asynchronous reset mid-show.
        tick(1);
        check("busy_show_led", led, 4'b0010);
        seed  = 16'h1234;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_start_led", led, 4'b0010);
        tick(1);
        check("busy_start_led2", led, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", led, 4'b0000);
        check("async_rst_busy", busy, 0);
        check("async_rst_score", score, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_idle", busy, 0);

        // Seed 0 behaves as seed 1; b1 held from ADD into WAIT is not a press.
        start_game(16'h0000);
        button = 4'b0010;
        expect_round(1);
        tick(5);
        check("held_echo", led, 4'b0010);
        check("held_score", score, 0);
        check("held_lose", lose, 0);
        check("held_busy", busy, 1);
        button = 4'b0000;
        tick(1);
        check("release_lose", lose, 0);
        press_step(1, 1);
        check("seed0_score", score, 1);

        // A wrong button during SHOW_ON is ignored.
        tick(1);
        button = 4'b1000;
        tick(1);
        button = 4'b0000;
        tick(11);
        check("show_press_lose", lose, 0);
        check("show_press_busy", busy, 1);
        press_step(1, 0);
        press_step(2, 1);
        check("show_press_score", score, 2);

        // Two buttons rising together lose.
        expect_round(3);
        button = 4'b0011;
        tick(1);
        button = 4'b0000;
        check("multi_lose", lose, 1);
        check("multi_score", score, 2);
        check("multi_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simon_dice_param.md
Name: simon_dice_param

Overview:
- Parametrised successor of the team's fixed 4-button Simon game.
- Generic button/LED count and maximum sequence length.
- Pseudo-random sequence from an LFSR that grows by one step per round; per-input timeout; score, win and lose outputs.
- Single clock domain: all pacing comes from cycle counters (clock enables), never from a derived clock. Sits between the debounced/synchronised button inputs and the LED drivers on the FPGA board.

Parameters:
N_BTN, 4, number of buttons/LEDs; power of two, 2..8; IDXW = log2(N_BTN)
MAX_LEN, 16, sequence length needed to win; 1..64; SW = $clog2(MAX_LEN+1)
SHOW_TICKS, 25000000, clk cycles each sequence LED is lit
GAP_TICKS, 12500000, clk cycles LEDs are dark between shown steps
TIMEOUT_TICKS, 250000000, clk cycles allowed between presses in WAIT

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; starts a new game from IDLE, WIN or LOSE; ignored while busy
seed  input  16  LFSR load value sampled on accepted start; 0 is replaced by 16'h0001
button  input  N_BTN  synchronised, debounced, active-high button levels
led  output  N_BTN  registered LED drive
score  output  SW  rounds completed in current/last game
busy  output  1  high in ADD, SHOW_ON, SHOW_OFF, WAIT
win  output  1  high in WIN
lose  output  1  high in LOSE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; led=0, score=0, busy=0, win=0, lose=0; len=0; lfsr=16'h0001; btn_prev=0; all timers and indices 0. Applies immediately mid-game; on release the block waits in IDLE for start.
- LFSR: 16-bit Fibonacci. fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}. Steps only in ADD.
- Sequence store: MAX_LEN entries x IDXW bits. Registers; no reset needed.
- Press detection: rise = button & ~btn_prev; btn_prev updates every cycle.
  - A press is a cycle with rise != 0. Valid press = exactly one bit set.
  - Held buttons and releases generate nothing.
- IDLE: led=0. start -> lfsr=seed (or 1), len=0, score=0, go ADD.
- ADD (1 cycle): mem[len] = lfsr[IDXW-1:0]; len=len+1; step lfsr; show_idx=0; timer=0; go SHOW_ON.
- SHOW_ON: led = one-hot(mem[show_idx]) for exactly SHOW_TICKS cycles, then SHOW_OFF.
- SHOW_OFF: led=0 for GAP_TICKS cycles. Then:
  - if show_idx == len-1: go WAIT with in_idx=0, timer=0;
  - else show_idx+1, go SHOW_ON.
- Presses during ADD/SHOW_* are ignored.
- WAIT: led = button (live echo, registered, 1-cycle lag); timer increments each cycle with no press.
  - Valid press equal to mem[in_idx]: timer=0.
    - If in_idx == len-1: score=len; if len==MAX_LEN go WIN, else go ADD.
    - Otherwise in_idx+1.
  - Press wrong index, or multi-bit rise: go LOSE.
  - timer reaches TIMEOUT_TICKS-1 with no press: go LOSE. Total wait = TIMEOUT_TICKS cycles.
  - Press and timeout in the same cycle: the press wins.
- WIN: led all ones, win=1, score held.
- LOSE: led=0, lose=1, score held (last completed round).
- In WIN/LOSE, start behaves as in IDLE (clears win/lose next cycle). start in IDLE/WIN/LOSE takes priority over nothing else; start while busy is ignored.
- All outputs registered; state changes take effect the cycle after the triggering edge.

Test Plan:
Common settings: N_BTN=4, MAX_LEN=3, SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20, seed=16'h0001 (sequence 1,2,0).
1. Reset, then start -> ADD 1 cycle; led=4'b0010 for 4 cycles, 0 for 2; busy=1 throughout; then WAIT.
2. Full win: press b1; round 2 shows 0010,0100; press b1,b2; round 3 shows 0010,0100,0001; press b1,b2,b0 -> led=4'b1111, win=1, score=3, busy=0.
3. Wrong press: round 1, press b3 -> lose=1, led=0, score=0. Then start -> lose=0 and new game with seed again shows 0010.
4. Timeout: round 2 WAIT, no press for 20 cycles -> lose=1, score=1. Press on cycle 19 instead -> accepted, no lose.
5. Button b1 held from SHOW_ON into WAIT -> no press registered. Simultaneous rise of b0|b1 -> LOSE. Presses during SHOW ignored (round unchanged).
6. rst_n low mid-SHOW_ON -> led=0, busy=0, score=0 asynchronously. start while busy has no effect. seed=0 -> behaves as seed=1.
